mips_hazard_ctrl: RTL

- Pipeline hazard and control unit for the 5-stage MIPS_32 core (IF/ID/EX/MEM/WB).
- Tracks destination and control bits of in-flight instructions in its own shadow pipeline.
- Drives forwarding selects into EX, load-use stalls, branch/jump flushes, and a data-memory wait freeze.
- Lets the existing pipeline buffers execute dependent code without software NOPs.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_hazard_ctrl_if.sv | 60 ++++++
 rtl/mips_fwd_sel.sv | 29 ++
 rtl/mips_hazard_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS_32 hazard/control unit.
package mips_pkg;

  localparam int unsigned ARCH_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;

  typedef struct packed {
    logic               valid;
    logic [ARCH_AW-1:0] dst;
    logic [ARCH_AW-1:0] rs;
    logic [ARCH_AW-1:0] rt;
    logic               regwrite;
    logic               memread;
    logic               memaccess;
  } shadow_t;

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; HAZARD_PERF_CNT_EN adds the counter outputs.
interface mips_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              br_taken;
  logic              jump;
  logic              dmem_ready;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_flush;
  logic              pipe_en;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_rs;
  logic              id_byp_rt;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;
  logic [CNT_W-1:0]  wait_cycles;
`else
  logic [CNT_W-1:0]  unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
           id_regwrite, id_memread, id_memwrite, br_taken, jump, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_events, wait_cycles,
`endif
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_en,
           fwd_a, fwd_b, id_byp_rs, id_byp_rt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
           id_regwrite, id_memread, id_memwrite, br_taken, jump, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_events, wait_cycles,
`endif
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_en,
           fwd_a, fwd_b, id_byp_rs, id_byp_rt
  );

endinterface

// File: rtl/mips_fwd_sel.sv
// One EX operand forwarding select from the MEM/WB shadow stages (MEM wins).
module mips_fwd_sel
  import mips_pkg::*;
(
  input  logic               mem_valid,
  input  logic               mem_regwrite,
  input  logic               mem_memread,
  input  logic [ARCH_AW-1:0] mem_dst,
  input  logic               wb_valid,
  input  logic               wb_regwrite,
  input  logic [ARCH_AW-1:0] wb_dst,
  input  logic [ARCH_AW-1:0] src,
  output logic [1:0]         sel_c
);

  logic mem_hit_c;
  logic wb_hit_c;

  // A load in MEM has no data yet; the stall path covers it instead.
  always_comb begin
    mem_hit_c = mem_valid && mem_regwrite && !mem_memread &&
                (mem_dst != '0) && (mem_dst == src);
    wb_hit_c  = wb_valid && wb_regwrite && (wb_dst != '0) && (wb_dst == src);
    sel_c     = FWD_REG;
    if (mem_hit_c)     sel_c = FWD_MEM;
    else if (wb_hit_c) sel_c = FWD_WB;
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard/control unit for the 5-stage MIPS_32 pipeline: forwarding, stalls, flushes, memory freeze.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/wait counters.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned RESOLVE_STAGE = 3,
  parameter int unsigned RF_BYPASS     = 1,
  parameter int unsigned CNT_W         = 32
) (
  input logic               clk,
  input logic               rst_n,
  mips_hazard_ctrl_if.slave hz
);

  shadow_t id_s;
  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;

  logic mem_wait_c;
  logic resolve_valid_c;
  logic redirect_c;
  logic load_use_c;
  logic unused_bits;

  // Snapshot of the decoded ID instruction; empty slots carry no register ids.
  always_comb begin
    id_s = '0;
    if (hz.id_valid) begin
      id_s.valid     = 1'b1;
      id_s.dst       = ARCH_AW'(hz.id_dst);
      id_s.rs        = ARCH_AW'(hz.id_rs);
      id_s.rt        = ARCH_AW'(hz.id_rt);
      id_s.regwrite  = hz.id_regwrite;
      id_s.memread   = hz.id_memread;
      id_s.memaccess = hz.id_memread | hz.id_memwrite;
    end
  end

  // Priority: memory wait > redirect > load-use > normal.
  always_comb begin
    mem_wait_c      = mem_q.valid && mem_q.memaccess && !hz.dmem_ready;
    resolve_valid_c = (RESOLVE_STAGE == STG_EX) ? ex_q.valid : mem_q.valid;
    redirect_c      = !mem_wait_c && resolve_valid_c && (hz.br_taken || hz.jump);
    load_use_c      = !mem_wait_c && !redirect_c &&
                      ex_q.valid && ex_q.memread && (ex_q.dst != '0) && hz.id_valid &&
                      ((hz.id_use_rs && (REG_AW'(ex_q.dst) == hz.id_rs)) ||
                       (hz.id_use_rt && (REG_AW'(ex_q.dst) == hz.id_rt)));

    hz.pc_we       = !mem_wait_c && !load_use_c;
    hz.ifid_we     = !mem_wait_c && !load_use_c;
    hz.pipe_en     = !mem_wait_c;
    hz.ifid_flush  = redirect_c;
    hz.idex_bubble = redirect_c || load_use_c;
    hz.exmem_flush = redirect_c && (RESOLVE_STAGE == STG_MEM);
  end

  // Shadow copies of ID/EX, EX/MEM, MEM/WB with the same bubble/flush behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (hz.pipe_en) begin
      ex_q  <= hz.idex_bubble ? '0 : id_s;
      mem_q <= hz.exmem_flush ? '0 : ex_q;
      wb_q  <= mem_q;
    end
  end

  mips_fwd_sel u_fwd_a (
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .mem_dst      (mem_q.dst),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_dst       (wb_q.dst),
    .src          (ex_q.rs),
    .sel_c        (hz.fwd_a)
  );

  mips_fwd_sel u_fwd_b (
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .mem_dst      (mem_q.dst),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_dst       (wb_q.dst),
    .src          (ex_q.rt),
    .sel_c        (hz.fwd_b)
  );

  // ID bypass only matters when the register file reads before it writes.
  if (RF_BYPASS == 0) begin : g_byp
    assign hz.id_byp_rs = wb_q.valid && wb_q.regwrite && (wb_q.dst != '0) &&
                          (REG_AW'(wb_q.dst) == hz.id_rs);
    assign hz.id_byp_rt = wb_q.valid && wb_q.regwrite && (wb_q.dst != '0) &&
                          (REG_AW'(wb_q.dst) == hz.id_rt);
  end else begin : g_no_byp
    assign hz.id_byp_rs = 1'b0;
    assign hz.id_byp_rt = 1'b0;
  end

  assign unused_bits = ^{wb_q.rs, wb_q.rt, wb_q.memread, wb_q.memaccess};

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] wait_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (load_use_c && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (redirect_c && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      if (mem_wait_c && !(&wait_q))  wait_q  <= wait_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.wait_cycles  = wait_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
